max_pop_queue: RTL and testbench



---
 rtl/max_pop_queue.sv | 92 +++++++++
 tb/tb_max_pop_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pop_queue.sv
// Sorted max-priority queue: unsorted pushes, largest-first pops, head always on dout.
// Storage is a register array kept in non-increasing order by compare-and-shift insertion.
module max_pop_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_e [DEPTH];
  logic [CW-1:0]         r_count;
  logic                  r_drop;

  logic [DATA_WIDTH-1:0] w_src  [DEPTH];
  logic [DATA_WIDTH-1:0] w_next [DEPTH];
  logic [CW-1:0]         w_src_cnt;
  logic [CW-1:0]         w_idx;
  logic [CW-1:0]         w_next_cnt;
  logic                  w_full;
  logic                  w_pop_eff;
  logic                  w_push_eff;
  logic                  w_drop_next;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop_eff  = pop && (r_count != '0);
  // A push into a full queue only survives when a pop frees the head slot.
  assign w_push_eff = push && (!w_full || w_pop_eff);
  assign w_drop_next = push && w_full && !w_pop_eff;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_src_cnt = r_count;
    for (int i = 0; i < DEPTH; i++) w_src[i] = r_e[i];
    if (w_pop_eff) begin
      w_src_cnt = r_count - CW'(1);
      for (int i = 0; i < DEPTH-1; i++) w_src[i] = r_e[i+1];
      w_src[DEPTH-1] = '0;
    end

    // Insertion point: number of live entries >= din, so ties land after equals.
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < w_src_cnt) && (w_src[i] >= din)) w_idx = w_idx + CW'(1);
    end

    for (int i = 0; i < DEPTH; i++) w_next[i] = w_src[i];
    if (w_push_eff) begin
      if (w_idx == '0) w_next[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        if (CW'(i) == w_idx)     w_next[i] = din;
        else if (CW'(i) > w_idx) w_next[i] = w_src[i-1];
      end
    end

    w_next_cnt = w_src_cnt + CW'(w_push_eff);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the entry array is reset too, because vacant slots must read 0
      // and dout must be 0 straight after reset.
      for (int i = 0; i < DEPTH; i++) r_e[i] <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_e[i] <= w_next[i];
      r_count <= w_next_cnt;
      r_drop  <= w_drop_next;
    end
  end

  assign dout  = r_e[0];
  assign valid = (r_count != '0);
  assign full  = w_full;
  assign count = r_count;
  assign drop  = r_drop;

endmodule

// File: tb/tb_max_pop_queue.sv
// Self-checking bench for max_pop_queue: directed scenarios plus random traffic
// compared against a sorted-queue reference model.
module tb_max_pop_queue;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH+1);
  localparam int VW         = DATA_WIDTH + CW + 3;

  logic                  clk;
  logic                  reset;
  logic                  push;
  logic [DATA_WIDTH-1:0] din;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  drop;

  int n_vec;
  int n_err;

  int unsigned q[$];
  bit          m_drop;

  max_pop_queue #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .valid (valid),
    .full  (full),
    .count (count),
    .drop  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a sorted list, largest first.
  task automatic model_insert(input int unsigned d);
    int k;
    k = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] < d) begin
        k = i;
        break;
      end
    end
    q.insert(k, d);
  endtask

  task automatic model_step(input bit r, input bit p, input bit po, input int unsigned d);
    m_drop = 1'b0;
    if (r) begin
      q.delete();
    end else begin
      if (po && q.size() > 0) void'(q.pop_front());
      if (p) begin
        if (q.size() < DEPTH) model_insert(d);
        else m_drop = 1'b1;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [DATA_WIDTH-1:0] d;
    d = (q.size() > 0) ? DATA_WIDTH'(q[0]) : '0;
    return {d, CW'(q.size()), q.size() != 0, q.size() == DEPTH, m_drop};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {dout, count, valid, full, drop};
  endfunction

  // Apply one cycle of inputs, advance past the edge, and update the model.
  task automatic step(input bit r, input bit p, input bit po, input int unsigned d);
    reset = r;
    push  = p;
    pop   = po;
    din   = DATA_WIDTH'(d);
    @(posedge clk);
    #1;
    model_step(r, p, po, d);
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 1'b1, 9);
    n_vec++;
    if (obs_vec() !== {{DATA_WIDTH{1'b0}}, {CW{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got %h want all zero", obs_vec());
    end
  endtask

  task automatic test_push_seq();
    int unsigned vals [4] = '{5, 9, 2, 7};
    int unsigned want_dout [4] = '{5, 9, 9, 9};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, vals[i]);
      n_vec++;
      if (obs_vec() !== exp_vec() || dout !== want_dout[i] || count !== CW'(i+1)) begin
        n_err++;
        $display("FAIL push_seq[%0d]: got %h want %h (dout %0d)", i, obs_vec(), exp_vec(), want_dout[i]);
      end
    end
    n_vec++;
    if (full !== 1'b1) begin
      n_err++;
      $display("FAIL push_full: got full=%0b want 1", full);
    end
  endtask

  task automatic test_pop_drain();
    int unsigned want_dout [4] = '{7, 5, 2, 0};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      n_vec++;
      if (obs_vec() !== exp_vec() || dout !== want_dout[i]) begin
        n_err++;
        $display("FAIL pop_drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    step(1'b0, 1'b0, 1'b1, 0);
    n_vec++;
    if (count !== '0 || drop !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL pop_empty: got count=%0d drop=%0b valid=%0b want 0 0 0", count, drop, valid);
    end
  endtask

  task automatic test_drop();
    int unsigned fill [4] = '{9, 7, 5, 2};
    int unsigned want [4] = '{7, 5, 2, 0};
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, fill[i]);
    step(1'b0, 1'b1, 1'b0, 8);
    n_vec++;
    if (obs_vec() !== exp_vec() || drop !== 1'b1 || dout !== 9) begin
      n_err++;
      $display("FAIL drop_pulse: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 1'b0, 0);
    n_vec++;
    if (drop !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL drop_one_cycle: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 1'b1, 8);
    n_vec++;
    if (obs_vec() !== exp_vec() || dout !== 8 || count !== CW'(4) || drop !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      n_vec++;
      if (obs_vec() !== exp_vec() || dout !== want[i]) begin
        n_err++;
        $display("FAIL drop_contents[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_pushpop();
    step(1'b0, 1'b1, 1'b0, 9);
    step(1'b0, 1'b1, 1'b0, 7);
    step(1'b0, 1'b1, 1'b1, 3);
    n_vec++;
    if (obs_vec() !== exp_vec() || dout !== 7 || count !== CW'(2)) begin
      n_err++;
      $display("FAIL pushpop_low: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 1'b1, 10);
    n_vec++;
    if (obs_vec() !== exp_vec() || dout !== 10 || count !== CW'(2)) begin
      n_err++;
      $display("FAIL pushpop_high: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 1'b1, 0);
    n_vec++;
    if (obs_vec() !== exp_vec() || dout !== 3) begin
      n_err++;
      $display("FAIL pushpop_tail: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_ties();
    int unsigned want [3] = '{4, 4, 0};
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      n_vec++;
      if (obs_vec() !== exp_vec() || dout !== want[i]) begin
        n_err++;
        $display("FAIL ties[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    step(1'b0, 1'b1, 1'b1, 6);
    n_vec++;
    if (obs_vec() !== exp_vec() || dout !== 6 || count !== CW'(1)) begin
      n_err++;
      $display("FAIL empty_pushpop: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 1'b1, 1'b0, 9);
    step(1'b0, 1'b1, 1'b0, 7);
    step(1'b0, 1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 1'b0, 12);
    n_vec++;
    if (count !== '0 || dout !== '0 || valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_mid: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 1'b0, 1);
    n_vec++;
    if (dout !== 1 || count !== CW'(1) || obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_mid_push: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit          r, p, po;
    int unsigned d;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      d  = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 12);
      step(r, p, po, d);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h (dout,count,valid,full,drop)", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_drop = 1'b0;
    reset  = 1'b1;
    push   = 1'b0;
    pop    = 1'b0;
    din    = '0;
    test_reset();
    test_push_seq();
    test_pop_drain();
    test_drop();
    test_pushpop();
    test_ties();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
